// File: rtl/mem_issue_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_issue_unit_pkg
//  Description : Shared rv32i types used by the memory issue unit: physical
//                register / ROB index types, opcode and funct3 encodings,
//                LSQ entry and CDB structures, and the issue FSM state type.
//  Revision    : 1.0  initial release
// ============================================================================
package mem_issue_unit_pkg;

    localparam int NUM_PHYS_REGS        = 64;
    localparam int PHYS_REG_BITS        = 6;
    localparam int NUM_ROB_ENTRIES_BITS = 4;
    localparam int MEM_BUS_BYTES        = 4;

    typedef logic [PHYS_REG_BITS-1:0] phys_reg;

    typedef enum logic [6:0] {
        op_imm   = 7'b0010011,
        op_load  = 7'b0000011,
        op_store = 7'b0100011
    } rv32i_opcode;

    typedef enum logic [2:0] {
        lb  = 3'b000,
        lh  = 3'b001,
        lw  = 3'b010,
        lbu = 3'b100,
        lhu = 3'b101
    } load_funct3_t;

    typedef enum logic [2:0] {
        sb = 3'b000,
        sh = 3'b001,
        sw = 3'b010
    } store_funct3_t;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc_rdata;
        logic [4:0]  rs1_addr;
        logic [4:0]  rs2_addr;
        logic [4:0]  rd_addr;
        logic [31:0] rs1_v;
        logic [31:0] rs2_v;
        logic [31:0] rd_wdata;
        logic [31:0] mem_addr;
        logic [3:0]  mem_rmask;
        logic [3:0]  mem_wmask;
        logic [31:0] mem_rdata;
        logic [31:0] mem_wdata;
    } rvfi_t;

    typedef struct packed {
        rv32i_opcode                     opcode;
        logic [2:0]                      funct3;
        phys_reg                         ps1_s;
        phys_reg                         ps2_s;
        phys_reg                         pd_s;
        logic [NUM_ROB_ENTRIES_BITS-1:0] rob_num;
        logic [31:0]                     i_imm;
        logic [31:0]                     s_imm;
        rvfi_t                           rvfi;
    } lsq_entry_t;

    typedef struct packed {
        logic                            valid;
        phys_reg                         pd_s;
        logic [31:0]                     pd_v;
        logic [NUM_ROB_ENTRIES_BITS-1:0] rob_num;
        logic                            br_en;
        logic                            instr_is_br;
        logic                            br_taken;
        rvfi_t                           rvfi_data;
    } cdb_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        REQ2  = 2'd2,
        DRAIN = 2'd3
    } mem_issue_state_t;

    // Access size in bytes for a load/store funct3 (byte, half, word).
    function automatic logic [2:0] size_from_funct3(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   size_from_funct3 = 3'd1;
            2'b01:   size_from_funct3 = 3'd2;
            default: size_from_funct3 = 3'd4;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_issue_unit_lane_align.sv
`default_nettype none
// ============================================================================
//  Module      : mem_lane_align
//  Description : Combinational byte-lane steering for one memory access.
//                Produces the beat-0/beat-1 byte masks and lane-shifted
//                store data, and merges two raw read beats into the
//                sign/zero-extended load value.
//  Revision    : 1.0  initial release
// ============================================================================
module mem_lane_align
    import mem_issue_unit_pkg::*;
#(
    parameter int BUS_BYTES = MEM_BUS_BYTES,
    parameter int OFF_W     = (BUS_BYTES == 8) ? 3 : 2
) (
    input  logic [OFF_W-1:0]       off,
    input  logic [2:0]             size,
    input  logic [2:0]             funct3,
    input  logic [31:0]            store_data,
    input  logic [8*BUS_BYTES-1:0] rdata0,
    input  logic [8*BUS_BYTES-1:0] rdata1,
    output logic [BUS_BYTES-1:0]   mask0,
    output logic [BUS_BYTES-1:0]   mask1,
    output logic [8*BUS_BYTES-1:0] wdata0,
    output logic [8*BUS_BYTES-1:0] wdata1,
    output logic [3:0]             word_mask,
    output logic [31:0]            raw_word,
    output logic [31:0]            load_value
);

    localparam int LANE_BITS = 8 * BUS_BYTES;

    logic [2*BUS_BYTES-1:0] wide_mask;
    logic [2*LANE_BITS-1:0] wide_wdata;
    logic [2*LANE_BITS-1:0] both_beats;

    assign both_beats = {rdata1, rdata0};

    // Byte-enable pattern of the access before it is placed on the bus.
    always_comb begin
        case (size)
            3'd1:    word_mask = 4'b0001;
            3'd2:    word_mask = 4'b0011;
            default: word_mask = 4'b1111;
        endcase
    end

    // Shift mask and store data across two bus words; the upper word is beat 1.
    always_comb begin
        wide_mask  = {{(2*BUS_BYTES-4){1'b0}}, word_mask} << off;
        wide_wdata = {{(2*LANE_BITS-32){1'b0}}, store_data} << {off, 3'b000};
    end

    assign mask0  = wide_mask[BUS_BYTES-1:0];
    assign mask1  = wide_mask[2*BUS_BYTES-1:BUS_BYTES];
    assign wdata0 = wide_wdata[LANE_BITS-1:0];
    assign wdata1 = wide_wdata[2*LANE_BITS-1:LANE_BITS];

    // Gather four consecutive bytes starting at the access offset.
    always_comb begin
        raw_word = '0;
        for (int i = 0; i < 4; i++) begin
            raw_word[8*i +: 8] = both_beats[8*(int'(off) + i) +: 8];
        end
    end

    // Sign/zero extension by load type.
    always_comb begin
        case (funct3)
            lb:      load_value = {{24{raw_word[7]}}, raw_word[7:0]};
            lbu:     load_value = {24'd0, raw_word[7:0]};
            lh:      load_value = {{16{raw_word[15]}}, raw_word[15:0]};
            lhu:     load_value = {16'd0, raw_word[15:0]};
            default: load_value = raw_word;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_issue_unit.sv
`default_nettype none
// ============================================================================
//  Module      : mem_issue_unit
//  Description : Issues the LSQ head load/store to the D-cache once it is at
//                the ROB head with valid operands. Supports 4- or 8-byte
//                cache buses, splits bus-word-crossing accesses into two
//                beats, drains outstanding requests on mispredict and
//                broadcasts the result on the CDB.
//                Optional: define MEM_ISSUE_RVFI_EN to populate
//                cdb.rvfi_data from latched entry state.
//  Revision    : 1.0  initial release
// ============================================================================
module mem_issue_unit
    import mem_issue_unit_pkg::*;
#(
    parameter int BUS_BYTES = MEM_BUS_BYTES,
    parameter int ROB_BITS  = NUM_ROB_ENTRIES_BITS
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     mispredict,
    input  lsq_entry_t               lsq_head,
    input  logic                     lsq_empty,
    output logic                     pop,
    input  logic [NUM_PHYS_REGS-1:0] valid_reg,
    output phys_reg                  ps1_s,
    output phys_reg                  ps2_s,
    input  logic [31:0]              ps1_v,
    input  logic [31:0]              ps2_v,
    input  logic [ROB_BITS-1:0]      rob_head,
    output cdb_t                     cdb,
    output logic [31:0]              d_cache_addr,
    output logic [BUS_BYTES-1:0]     d_cache_rmask,
    output logic [BUS_BYTES-1:0]     d_cache_wmask,
    output logic [8*BUS_BYTES-1:0]   d_cache_wdata,
    input  logic [8*BUS_BYTES-1:0]   d_cache_rdata,
    input  logic                     d_cache_resp
);

    localparam int OFF_W     = (BUS_BYTES == 8) ? 3 : 2;
    localparam int LANE_BITS = 8 * BUS_BYTES;

    mem_issue_state_t                state_q, state_d;
    logic [31:0]                     ea_q, ea_d;
    logic [2:0]                      funct3_q, funct3_d;
    logic                            is_store_q, is_store_d;
    logic                            split_q, split_d;
    logic [31:0]                     wdata_q, wdata_d;
    phys_reg                         pd_s_q, pd_s_d;
    logic [NUM_ROB_ENTRIES_BITS-1:0] rob_num_q, rob_num_d;
    logic [LANE_BITS-1:0]            beat0_q, beat0_d;
    logic                            beat1_q, beat1_d;

    logic                 is_load, is_store, ready, issue, complete, active;
    logic [31:0]          ea;
    logic [2:0]           size_in;
    logic                 split_in;
    logic [BUS_BYTES-1:0] mask0, mask1, cur_mask;
    logic [LANE_BITS-1:0] wdata0, wdata1, rdata_lo;
    logic [3:0]           word_mask;
    logic [31:0]          raw_word, load_value;

    assign ps1_s = lsq_head.ps1_s;
    assign ps2_s = lsq_head.ps2_s;

    assign is_load  = (lsq_head.opcode == op_load);
    assign is_store = (lsq_head.opcode == op_store);
    assign ready    = !lsq_empty && (rob_head == lsq_head.rob_num) &&
                      ((is_load && valid_reg[lsq_head.ps1_s]) ||
                       (is_store && valid_reg[lsq_head.ps1_s] && valid_reg[lsq_head.ps2_s]));
    assign issue    = (state_q == IDLE) && ready && !mispredict;

    assign ea       = ps1_v + (is_store ? lsq_head.s_imm : lsq_head.i_imm);
    assign size_in  = size_from_funct3(lsq_head.funct3);
    assign split_in = (int'(ea[OFF_W-1:0]) + int'(size_in)) > BUS_BYTES;

    // Beat 1 merges the captured beat-0 word with the word arriving now.
    assign rdata_lo = beat1_q ? beat0_q : d_cache_rdata;

    mem_lane_align #(
        .BUS_BYTES (BUS_BYTES),
        .OFF_W     (OFF_W)
    ) u_align (
        .off        (ea_q[OFF_W-1:0]),
        .size       (size_from_funct3(funct3_q)),
        .funct3     (funct3_q),
        .store_data (wdata_q),
        .rdata0     (rdata_lo),
        .rdata1     (d_cache_rdata),
        .mask0      (mask0),
        .mask1      (mask1),
        .wdata0     (wdata0),
        .wdata1     (wdata1),
        .word_mask  (word_mask),
        .raw_word   (raw_word),
        .load_value (load_value)
    );

    // Request outputs come only from latched state; DRAIN keeps them held.
    assign active        = (state_q != IDLE);
    assign cur_mask      = beat1_q ? mask1 : mask0;
    assign d_cache_addr  = {ea_q[31:OFF_W], {OFF_W{1'b0}}} + (beat1_q ? 32'(BUS_BYTES) : 32'd0);
    assign d_cache_rmask = (active && !is_store_q) ? cur_mask : '0;
    assign d_cache_wmask = (active &&  is_store_q) ? cur_mask : '0;
    assign d_cache_wdata = beat1_q ? wdata1 : wdata0;
    assign pop           = complete;

    // Next-state and request-register update.
    always_comb begin
        state_d    = state_q;
        ea_d       = ea_q;
        funct3_d   = funct3_q;
        is_store_d = is_store_q;
        split_d    = split_q;
        wdata_d    = wdata_q;
        pd_s_d     = pd_s_q;
        rob_num_d  = rob_num_q;
        beat0_d    = beat0_q;
        beat1_d    = beat1_q;
        complete   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (issue) begin
                    ea_d       = ea;
                    funct3_d   = lsq_head.funct3;
                    is_store_d = is_store;
                    split_d    = split_in;
                    wdata_d    = ps2_v;
                    pd_s_d     = lsq_head.pd_s;
                    rob_num_d  = lsq_head.rob_num;
                    beat1_d    = 1'b0;
                    state_d    = REQ;
                end
            end
            REQ: begin
                if (d_cache_resp) begin
                    if (mispredict) begin
                        state_d = IDLE;
                    end else if (split_q) begin
                        beat0_d = d_cache_rdata;
                        beat1_d = 1'b1;
                        state_d = REQ2;
                    end else begin
                        complete = 1'b1;
                        state_d  = IDLE;
                    end
                end else if (mispredict) begin
                    state_d = DRAIN;
                end
            end
            REQ2: begin
                if (d_cache_resp) begin
                    complete = !mispredict;
                    state_d  = IDLE;
                end else if (mispredict) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (d_cache_resp) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and request registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            ea_q       <= '0;
            funct3_q   <= '0;
            is_store_q <= 1'b0;
            split_q    <= 1'b0;
            wdata_q    <= '0;
            pd_s_q     <= '0;
            rob_num_q  <= '0;
            beat0_q    <= '0;
            beat1_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            ea_q       <= ea_d;
            funct3_q   <= funct3_d;
            is_store_q <= is_store_d;
            split_q    <= split_d;
            wdata_q    <= wdata_d;
            pd_s_q     <= pd_s_d;
            rob_num_q  <= rob_num_d;
            beat0_q    <= beat0_d;
            beat1_q    <= beat1_d;
        end
    end

`ifdef MEM_ISSUE_RVFI_EN
    rvfi_t       rvfi_q, rvfi_d;
    logic [31:0] ps1_v_q, ps1_v_d;
    logic [31:0] wdata_merged;

    // Capture the monitor record and base operand alongside the request.
    always_comb begin
        rvfi_d  = rvfi_q;
        ps1_v_d = ps1_v_q;
        if (issue) begin
            rvfi_d  = lsq_head.rvfi;
            ps1_v_d = ps1_v;
        end
    end

    // Monitor registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rvfi_q  <= '0;
            ps1_v_q <= '0;
        end else begin
            rvfi_q  <= rvfi_d;
            ps1_v_q <= ps1_v_d;
        end
    end

    // Store data restricted to the bytes actually written.
    always_comb begin
        wdata_merged = '0;
        for (int i = 0; i < 4; i++) begin
            if (word_mask[i]) begin
                wdata_merged[8*i +: 8] = wdata_q[8*i +: 8];
            end
        end
    end
`else
    logic unused_rvfi;
    assign unused_rvfi = ^{1'b0, lsq_head.rvfi, word_mask, raw_word};
`endif

    // Result broadcast.
    always_comb begin
        cdb             = '0;
        cdb.valid       = complete;
        cdb.pd_s        = is_store_q ? '0 : pd_s_q;
        cdb.pd_v        = is_store_q ? 32'd0 : load_value;
        cdb.rob_num     = rob_num_q;
        cdb.br_en       = 1'b0;
        cdb.instr_is_br = 1'b0;
        cdb.br_taken    = 1'b0;
`ifdef MEM_ISSUE_RVFI_EN
        cdb.rvfi_data           = rvfi_q;
        cdb.rvfi_data.rs1_v     = ps1_v_q;
        cdb.rvfi_data.rs2_v     = wdata_q;
        cdb.rvfi_data.rd_wdata  = is_store_q ? 32'd0 : load_value;
        cdb.rvfi_data.mem_addr  = {ea_q[31:OFF_W], {OFF_W{1'b0}}};
        cdb.rvfi_data.mem_rmask = is_store_q ? 4'd0 : word_mask;
        cdb.rvfi_data.mem_wmask = is_store_q ? word_mask : 4'd0;
        cdb.rvfi_data.mem_rdata = is_store_q ? 32'd0 : raw_word;
        cdb.rvfi_data.mem_wdata = is_store_q ? wdata_merged : 32'd0;
`endif
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_issue_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_issue_unit
//  Description : Directed self-checking bench for mem_issue_unit with one
//                4-byte-bus and one 8-byte-bus instance.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mem_issue_unit;
    import mem_issue_unit_pkg::*;

    logic                            clk = 1'b0;
    logic                            rst_n;
    logic                            mispredict;
    logic [NUM_PHYS_REGS-1:0]        valid_reg;
    logic [31:0]                     ps1_v, ps2_v;
    logic [NUM_ROB_ENTRIES_BITS-1:0] rob_head;

    lsq_entry_t  head4, head8;
    logic        empty4, empty8, pop4, pop8, resp4, resp8;
    phys_reg     s1_4, s2_4, s1_8, s2_8;
    cdb_t        cdb4, cdb8;
    logic [31:0] addr4, addr8;
    logic [3:0]  rmask4, wmask4;
    logic [7:0]  rmask8, wmask8;
    logic [31:0] wdata4, rdata4;
    logic [63:0] wdata8, rdata8;

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    mem_issue_unit #(.BUS_BYTES(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .mispredict(mispredict),
        .lsq_head(head4), .lsq_empty(empty4), .pop(pop4),
        .valid_reg(valid_reg), .ps1_s(s1_4), .ps2_s(s2_4),
        .ps1_v(ps1_v), .ps2_v(ps2_v), .rob_head(rob_head), .cdb(cdb4),
        .d_cache_addr(addr4), .d_cache_rmask(rmask4), .d_cache_wmask(wmask4),
        .d_cache_wdata(wdata4), .d_cache_rdata(rdata4), .d_cache_resp(resp4)
    );

    mem_issue_unit #(.BUS_BYTES(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .mispredict(mispredict),
        .lsq_head(head8), .lsq_empty(empty8), .pop(pop8),
        .valid_reg(valid_reg), .ps1_s(s1_8), .ps2_s(s2_8),
        .ps1_v(ps1_v), .ps2_v(ps2_v), .rob_head(rob_head), .cdb(cdb8),
        .d_cache_addr(addr8), .d_cache_rmask(rmask8), .d_cache_wmask(wmask8),
        .d_cache_wdata(wdata8), .d_cache_rdata(rdata8), .d_cache_resp(resp8)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic lsq_entry_t mk(input rv32i_opcode op, input logic [2:0] f3,
                                      input logic [31:0] imm, input phys_reg pd,
                                      input logic [NUM_ROB_ENTRIES_BITS-1:0] rob);
        lsq_entry_t e;
        e         = '0;
        e.opcode  = op;
        e.funct3  = f3;
        e.ps1_s   = 6'd1;
        e.ps2_s   = 6'd2;
        e.pd_s    = pd;
        e.rob_num = rob;
        e.i_imm   = (op == op_load)  ? imm : 32'd0;
        e.s_imm   = (op == op_store) ? imm : 32'd0;
        return e;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; mispredict = 1'b0; valid_reg = '1;
        ps1_v = 32'h0000_1000; ps2_v = 32'd0; rob_head = 4'd3;
        head4 = '0; head8 = '0; empty4 = 1'b1; empty8 = 1'b1;
        resp4 = 1'b0; resp8 = 1'b0; rdata4 = '0; rdata8 = '0;
        #1;
        check("rst_rmask4", 64'(rmask4), 64'h0);
        check("rst_wmask4", 64'(wmask4), 64'h0);
        check("rst_pop4",   64'(pop4),   64'h0);
        check("rst_cdbv4",  64'(cdb4.valid), 64'h0);
        check("rst_rmask8", 64'(rmask8), 64'h0);
        tick(); tick(); rst_n = 1'b1;

        // lw at 0x1000 on the 4-byte bus, response 3 cycles after request
        tick(); head4 = mk(op_load, lw, 32'd0, 6'd5, 4'd3); empty4 = 1'b0; #1;
        check("lw_idle_rmask", 64'(rmask4), 64'h0);
        tick(); #1;
        check("lw_addr",  64'(addr4),  64'h1000);
        check("lw_rmask", 64'(rmask4), 64'hF);
        check("lw_pop_early", 64'(pop4), 64'h0);
        tick(); tick(); #1;
        check("lw_cdbv_wait", 64'(cdb4.valid), 64'h0);
        tick(); resp4 = 1'b1; rdata4 = 32'h1234_5678; #1;
        check("lw_pop",   64'(pop4),        64'h1);
        check("lw_cdbv",  64'(cdb4.valid),  64'h1);
        check("lw_pdv",   64'(cdb4.pd_v),   64'h1234_5678);
        check("lw_pds",   64'(cdb4.pd_s),   64'h5);
        check("lw_rob",   64'(cdb4.rob_num), 64'h3);
        tick(); resp4 = 1'b0; empty4 = 1'b1; #1;
        check("lw_pop_once",  64'(pop4),       64'h0);
        check("lw_cdbv_once", 64'(cdb4.valid), 64'h0);

        // lb / lbu at 0x1003, then lh at 0x1002
        tick(); head4 = mk(op_load, lb, 32'd3, 6'd5, 4'd3); empty4 = 1'b0;
        tick(); resp4 = 1'b1; rdata4 = 32'h80AA_BBCC; #1;
        check("lb_addr",  64'(addr4),      64'h1000);
        check("lb_rmask", 64'(rmask4),     64'h8);
        check("lb_pdv",   64'(cdb4.pd_v),  64'hFFFF_FF80);
        check("lb_pop",   64'(pop4),       64'h1);
        tick(); resp4 = 1'b0; head4 = mk(op_load, lbu, 32'd3, 6'd5, 4'd3);
        tick(); resp4 = 1'b1; #1;
        check("lbu_rmask", 64'(rmask4),    64'h8);
        check("lbu_pdv",   64'(cdb4.pd_v), 64'h0000_0080);
        tick(); resp4 = 1'b0; head4 = mk(op_load, lh, 32'd2, 6'd5, 4'd3);
        tick(); resp4 = 1'b1; rdata4 = 32'h8001_0000; #1;
        check("lh_rmask", 64'(rmask4),    64'hC);
        check("lh_pdv",   64'(cdb4.pd_v), 64'hFFFF_8001);
        tick(); resp4 = 1'b0; empty4 = 1'b1;

        // mispredict in IDLE blocks issue; then mispredict after a request drains
        tick(); head4 = mk(op_load, lw, 32'd0, 6'd6, 4'd3); empty4 = 1'b0; mispredict = 1'b1;
        tick(); mispredict = 1'b0; #1;
        check("mp_idle_noissue", 64'(rmask4), 64'h0);
        tick(); #1;
        check("mp_req_rmask", 64'(rmask4), 64'hF);
        tick(); mispredict = 1'b1; #1;
        check("mp_req_held", 64'(rmask4), 64'hF);
        tick(); mispredict = 1'b0; #1;
        check("mp_drain_rmask", 64'(rmask4), 64'hF);
        check("mp_drain_addr",  64'(addr4),  64'h1000);
        tick(); resp4 = 1'b1; rdata4 = 32'hDEAD_BEEF; #1;
        check("mp_drain_pop",  64'(pop4),       64'h0);
        check("mp_drain_cdbv", 64'(cdb4.valid), 64'h0);
        tick(); resp4 = 1'b0; head4 = mk(op_load, lw, 32'd0, 6'd7, 4'd3); #1;
        check("mp_after_idle", 64'(rmask4), 64'h0);
        tick(); #1;
        check("mp_next_issue", 64'(rmask4), 64'hF);

        // asynchronous reset while a request is outstanding
        #1 rst_n = 1'b0; #1;
        check("arst_rmask", 64'(rmask4),     64'h0);
        check("arst_cdbv",  64'(cdb4.valid), 64'h0);
        check("arst_pop",   64'(pop4),       64'h0);
        empty4 = 1'b1;
        tick(); rst_n = 1'b1;
        tick();

        // sh at 0x1006 on the 8-byte bus
        tick(); ps2_v = 32'h0000_BEEF; head8 = mk(op_store, sh, 32'd6, 6'd7, 4'd3); empty8 = 1'b0;
        tick(); resp8 = 1'b1; #1;
        check("sh_addr",  64'(addr8),  64'h1000);
        check("sh_wmask", 64'(wmask8), 64'hC0);
        check("sh_rmask", 64'(rmask8), 64'h0);
        check("sh_wdata", 64'(wdata8[63:48]), 64'hBEEF);
        check("sh_pop",   64'(pop8),       64'h1);
        check("sh_cdbv",  64'(cdb8.valid), 64'h1);
        check("sh_pds",   64'(cdb8.pd_s),  64'h0);
        check("sh_pdv",   64'(cdb8.pd_v),  64'h0);

        // split lw at 0x1006 on the 8-byte bus
        tick(); resp8 = 1'b0; head8 = mk(op_load, lw, 32'd6, 6'd9, 4'd3);
        tick(); resp8 = 1'b1; rdata8 = 64'h1122_3344_5566_7788; #1;
        check("split_b0_addr",  64'(addr8),  64'h1000);
        check("split_b0_rmask", 64'(rmask8), 64'hC0);
        check("split_b0_pop",   64'(pop8),   64'h0);
        check("split_b0_cdbv",  64'(cdb8.valid), 64'h0);
        tick(); resp8 = 1'b0; #1;
        check("split_b1_addr",  64'(addr8),  64'h1008);
        check("split_b1_rmask", 64'(rmask8), 64'h03);
        tick(); resp8 = 1'b1; rdata8 = 64'hAAAA_AAAA_AAAA_9988; #1;
        check("split_pop",  64'(pop8),       64'h1);
        check("split_pdv",  64'(cdb8.pd_v),  64'h9988_1122);
        check("split_pds",  64'(cdb8.pd_s),  64'h9);
        tick(); resp8 = 1'b0; empty8 = 1'b1; #1;
        check("split_pop_once", 64'(pop8), 64'h0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
`default_nettype wire
